// File: rtl/axi_write_burst_arbiter_if.sv
// One AXI write channel bundle (AW, W, B). The arbiter sees each requester
// through the slave modport and drives the shared downstream port through the master modport.
interface axi_write_burst_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  // Requesters never supply wlast; the arbiter builds it from the latched length.
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_write_burst_arbiter.sv
// Two-requester AXI write arbiter granting one whole burst (AW, W, B) at a time.
// Define WR_ARB_FIXED_PRIO_EN for fixed r0-first priority; default is round-robin.
module axi_write_burst_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic                        clk,
  input  logic                        resetn,
  axi_write_burst_arbiter_if.slave    r0,
  axi_write_burst_arbiter_if.slave    r1,
  axi_write_burst_arbiter_if.master   m_axi,
  output logic [1:0]                  grant
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_q, beat_d;

  logic          sel1;
  logic          pick1;
  logic          wlastNow;
  logic [AW-1:0] awaddrMux;
  logic [7:0]    awlenMux;
  logic [2:0]    awsizeMux;
  logic [1:0]    awburstMux;
  logic          awvalidMux;
  logic [DW-1:0] wdataMux;
  logic [SW-1:0] wstrbMux;
  logic          wvalidMux;
  logic          breadyMux;

`ifdef WR_ARB_FIXED_PRIO_EN
  assign pick1 = r1.awvalid & ~r0.awvalid;
`else
  logic prio_q, prio_d;
  // prio_q set means r1 is preferred on a simultaneous request.
  assign pick1 = r1.awvalid & (~r0.awvalid | prio_q);
`endif

  assign sel1     = grant_q[1];
  assign wlastNow = (beat_q == len_q);
  assign grant    = grant_q;

  assign awaddrMux  = sel1 ? r1.awaddr  : r0.awaddr;
  assign awlenMux   = sel1 ? r1.awlen   : r0.awlen;
  assign awsizeMux  = sel1 ? r1.awsize  : r0.awsize;
  assign awburstMux = sel1 ? r1.awburst : r0.awburst;
  assign awvalidMux = sel1 ? r1.awvalid : r0.awvalid;
  assign wdataMux   = sel1 ? r1.wdata   : r0.wdata;
  assign wstrbMux   = sel1 ? r1.wstrb   : r0.wstrb;
  assign wvalidMux  = sel1 ? r1.wvalid  : r0.wvalid;
  assign breadyMux  = sel1 ? r1.bready  : r0.bready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
`ifndef WR_ARB_FIXED_PRIO_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
`ifndef WR_ARB_FIXED_PRIO_EN
      prio_q  <= prio_d;
`endif
    end
  end

  // Every channel is a pure pass-through while its phase is active and forced to zero otherwise.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    beat_d  = beat_q;
`ifndef WR_ARB_FIXED_PRIO_EN
    prio_d  = prio_q;
`endif

    m_axi.awaddr  = '0;
    m_axi.awlen   = 8'd0;
    m_axi.awsize  = 3'd0;
    m_axi.awburst = 2'd0;
    m_axi.awvalid = 1'b0;
    m_axi.wdata   = '0;
    m_axi.wstrb   = '0;
    m_axi.wlast   = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;

    r0.awready = 1'b0;
    r1.awready = 1'b0;
    r0.wready  = 1'b0;
    r1.wready  = 1'b0;
    r0.bresp   = 2'b00;
    r1.bresp   = 2'b00;
    r0.bvalid  = 1'b0;
    r1.bvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (r0.awvalid | r1.awvalid) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          len_d   = pick1 ? r1.awlen : r0.awlen;
          beat_d  = 8'd0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        m_axi.awaddr  = awaddrMux;
        m_axi.awlen   = awlenMux;
        m_axi.awsize  = awsizeMux;
        m_axi.awburst = awburstMux;
        m_axi.awvalid = awvalidMux;
        r0.awready    = ~sel1 & m_axi.awready;
        r1.awready    =  sel1 & m_axi.awready;
        if (awvalidMux & m_axi.awready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        m_axi.wdata  = wdataMux;
        m_axi.wstrb  = wstrbMux;
        m_axi.wvalid = wvalidMux;
        m_axi.wlast  = wlastNow;
        r0.wready    = ~sel1 & m_axi.wready;
        r1.wready    =  sel1 & m_axi.wready;
        // The final beat leaves beat_q at len_q, so a 256-beat burst never wraps.
        if (wvalidMux & m_axi.wready) begin
          if (wlastNow) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      RESP: begin
        m_axi.bready = breadyMux;
        r0.bresp     = sel1 ? 2'b00 : m_axi.bresp;
        r1.bresp     = sel1 ? m_axi.bresp : 2'b00;
        r0.bvalid    = ~sel1 & m_axi.bvalid;
        r1.bvalid    =  sel1 & m_axi.bvalid;
        if (m_axi.bvalid & breadyMux) begin
          grant_d = 2'b00;
          state_d = IDLE;
`ifndef WR_ARB_FIXED_PRIO_EN
          prio_d  = ~sel1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_write_burst_arbiter.sv
// Directed self-checking bench for axi_write_burst_arbiter: single bursts, ties,
// busy-time requests, length extremes, early W data and mid-burst reset.
module tb_axi_write_burst_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] grant;

  int total = 0;
  int bad   = 0;

  logic [1:0]    awvalidD, wvalidD, breadyD;
  logic [31:0]   awaddrD [2];
  logic [7:0]    awlenD  [2];
  logic [63:0]   wdataD  [2];
  logic          mAwready, mWready, mBvalid;
  logic [1:0]    mBresp;

  logic [1:0]    awreadyO, wreadyO, bvalidO;
  logic [1:0]    brespO [2];

  axi_write_burst_arbiter_if #(.AW(AW), .DW(DW)) r0_if ();
  axi_write_burst_arbiter_if #(.AW(AW), .DW(DW)) r1_if ();
  axi_write_burst_arbiter_if #(.AW(AW), .DW(DW)) m_if ();

  axi_write_burst_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .r0     (r0_if),
    .r1     (r1_if),
    .m_axi  (m_if),
    .grant  (grant)
  );

  always #5 clk = ~clk;

  // Requester-side drive
  assign r0_if.awaddr  = awaddrD[0];
  assign r1_if.awaddr  = awaddrD[1];
  assign r0_if.awlen   = awlenD[0];
  assign r1_if.awlen   = awlenD[1];
  assign r0_if.awsize  = 3'd3;
  assign r1_if.awsize  = 3'd3;
  assign r0_if.awburst = 2'b01;
  assign r1_if.awburst = 2'b01;
  assign r0_if.awvalid = awvalidD[0];
  assign r1_if.awvalid = awvalidD[1];
  assign r0_if.wdata   = wdataD[0];
  assign r1_if.wdata   = wdataD[1];
  assign r0_if.wstrb   = 8'hFF;
  assign r1_if.wstrb   = 8'hFF;
  assign r0_if.wlast   = 1'b0;
  assign r1_if.wlast   = 1'b0;
  assign r0_if.wvalid  = wvalidD[0];
  assign r1_if.wvalid  = wvalidD[1];
  assign r0_if.bready  = breadyD[0];
  assign r1_if.bready  = breadyD[1];

  // Slave-side drive
  assign m_if.awready = mAwready;
  assign m_if.wready  = mWready;
  assign m_if.bvalid  = mBvalid;
  assign m_if.bresp   = mBresp;

  assign awreadyO  = {r1_if.awready, r0_if.awready};
  assign wreadyO   = {r1_if.wready, r0_if.wready};
  assign bvalidO   = {r1_if.bvalid, r0_if.bvalid};
  assign brespO[0] = r0_if.bresp;
  assign brespO[1] = r1_if.bresp;

  function automatic logic [63:0] expData(input int who, input int beat);
    return {((who == 1) ? 32'hB1B1_0000 : 32'hA0A0_0000), beat[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearDrivers();
    awvalidD = 2'b00;
    wvalidD  = 2'b00;
    breadyD  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      awaddrD[i] = 32'd0;
      awlenD[i]  = 8'd0;
      wdataD[i]  = 64'd0;
    end
    mAwready = 1'b0;
    mWready  = 1'b0;
    mBvalid  = 1'b0;
    mBresp   = 2'b00;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    clearDrivers();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Runs one burst for requester 'who' starting in IDLE just after a falling edge.
  // otherMode: 0 other idle, 1 other requests in the same IDLE cycle, 2 other requests during DATA.
  task automatic applyStimulus(input int who, input logic [7:0] len, input logic [31:0] addr,
                               input int otherMode, input int awDelay, input bit earlyW,
                               input bit toggleW);
    int         oth;
    int         beat;
    int         cyc;
    int         lastSeen;
    bit         hs;
    logic [1:0] oh;
    oth = 1 - who;
    oh  = (who == 1) ? 2'b10 : 2'b01;

    awaddrD[who]  = addr;
    awlenD[who]   = len;
    awvalidD[who] = 1'b1;
    if (otherMode == 1) awvalidD[oth] = 1'b1;
    if (earlyW) begin
      wvalidD[who] = 1'b1;
      wdataD[who]  = expData(who, 0);
    end
    mAwready = (awDelay == 0);
    mWready  = 1'b1;
    #1;
    checkOutput("idle_grant", grant, 2'b00);
    checkOutput("idle_m_awvalid", m_if.awvalid, 1'b0);
    checkOutput("idle_awready", awreadyO, 2'b00);

    for (int i = 0; i < awDelay; i++) begin
      @(negedge clk);
      #1;
      checkOutput("addr_wait_grant", grant, oh);
      checkOutput("addr_wait_m_awvalid", m_if.awvalid, 1'b1);
      checkOutput("addr_wait_awready", awreadyO, 2'b00);
      checkOutput("addr_wait_wready", wreadyO, 2'b00);
      checkOutput("addr_wait_m_wvalid", m_if.wvalid, 1'b0);
    end

    @(negedge clk);
    mAwready = 1'b1;
    #1;
    checkOutput("addr_grant", grant, oh);
    checkOutput("addr_m_awvalid", m_if.awvalid, 1'b1);
    checkOutput("addr_m_awaddr", m_if.awaddr, addr);
    checkOutput("addr_m_awlen", m_if.awlen, len);
    checkOutput("addr_awready", awreadyO, oh);
    checkOutput("addr_wready", wreadyO, 2'b00);

    @(negedge clk);
    awvalidD[who] = 1'b0;
    awlenD[who]   = ~len;
    mAwready      = 1'b0;
    if (otherMode == 2) awvalidD[oth] = 1'b1;

    beat     = 0;
    cyc      = 0;
    lastSeen = 0;
    while (beat <= int'(len) && cyc < 600) begin
      wvalidD[who] = 1'b1;
      wdataD[who]  = expData(who, beat);
      mWready      = (!toggleW) || (cyc % 2 == 1);
      #1;
      checkOutput("data_m_wvalid", m_if.wvalid, 1'b1);
      checkOutput("data_m_wdata", m_if.wdata, expData(who, beat));
      checkOutput("data_m_wlast", m_if.wlast, (beat == int'(len)));
      checkOutput("data_wready", wreadyO, mWready ? oh : 2'b00);
      checkOutput("data_awready", awreadyO, 2'b00);
      hs = mWready;
      if (hs && m_if.wlast) lastSeen++;
      @(negedge clk);
      if (hs) beat++;
      cyc++;
    end
    checkOutput("data_within_budget", (beat > int'(len)), 1'b1);
    checkOutput("wlast_count", lastSeen, 1);

    wvalidD[who] = 1'b0;
    mWready      = 1'b0;
    mBvalid      = 1'b1;
    mBresp       = 2'b01;
    breadyD[who] = 1'b0;
    breadyD[oth] = 1'b1;
    #1;
    checkOutput("resp_m_bready_stall", m_if.bready, 1'b0);
    checkOutput("resp_bvalid", bvalidO, oh);
    checkOutput("resp_m_wvalid", m_if.wvalid, 1'b0);
    checkOutput("resp_m_wlast", m_if.wlast, 1'b0);

    @(negedge clk);
    breadyD[who] = 1'b1;
    #1;
    checkOutput("resp_m_bready", m_if.bready, 1'b1);
    checkOutput("resp_bresp_own", brespO[who], 2'b01);
    checkOutput("resp_bresp_other", brespO[oth], 2'b00);
    checkOutput("resp_grant", grant, oh);

    @(negedge clk);
    mBvalid = 1'b0;
    mBresp  = 2'b00;
    breadyD = 2'b00;
    #1;
    checkOutput("post_grant", grant, 2'b00);
    checkOutput("post_bvalid", bvalidO, 2'b00);
    checkOutput("post_m_bready", m_if.bready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    resetn = 1'b0;
    clearDrivers();
    #1;
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_m_awvalid", m_if.awvalid, 1'b0);
    checkOutput("rst_m_awaddr", m_if.awaddr, 32'd0);
    checkOutput("rst_m_wvalid", m_if.wvalid, 1'b0);
    checkOutput("rst_m_wlast", m_if.wlast, 1'b0);
    checkOutput("rst_m_bready", m_if.bready, 1'b0);
    checkOutput("rst_awready", awreadyO, 2'b00);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] single r0 burst, awlen=3");
    applyStimulus(0, 8'd3, 32'h0000_1000, 0, 0, 1'b0, 1'b0);

    $display("[TB] two ties in a row");
    doReset();
    awaddrD[1] = 32'h0000_2000;
    awlenD[1]  = 8'd2;
    applyStimulus(0, 8'd1, 32'h0000_1100, 1, 0, 1'b0, 1'b0);
    applyStimulus(1, 8'd2, 32'h0000_2000, 0, 0, 1'b0, 1'b0);
    awaddrD[1] = 32'h0000_2100;
    awlenD[1]  = 8'd1;
    applyStimulus(0, 8'd2, 32'h0000_1200, 1, 0, 1'b0, 1'b0);
    applyStimulus(1, 8'd1, 32'h0000_2100, 0, 0, 1'b0, 1'b0);

    $display("[TB] r1 request during r0 data phase");
    awaddrD[1] = 32'h0000_2200;
    awlenD[1]  = 8'd4;
    applyStimulus(0, 8'd7, 32'h0000_1300, 2, 0, 1'b0, 1'b0);
    applyStimulus(1, 8'd4, 32'h0000_2200, 0, 0, 1'b0, 1'b0);

    $display("[TB] awlen extremes with toggling wready");
    applyStimulus(1, 8'd0, 32'h0000_2300, 0, 0, 1'b0, 1'b1);
    applyStimulus(0, 8'd255, 32'h0000_1400, 0, 0, 1'b0, 1'b1);

    $display("[TB] early W data with delayed awready");
    applyStimulus(0, 8'd1, 32'h0000_1500, 0, 3, 1'b1, 1'b0);

    $display("[TB] reset during beat 2 of 4");
    awaddrD[0]  = 32'h0000_1600;
    awlenD[0]   = 8'd3;
    awvalidD[0] = 1'b1;
    mAwready    = 1'b1;
    mWready     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    awvalidD[0] = 1'b0;
    mAwready    = 1'b0;
    wvalidD[0]  = 1'b1;
    wdataD[0]   = expData(0, 0);
    #1;
    checkOutput("prerst_m_wdata", m_if.wdata, expData(0, 0));
    @(negedge clk);
    wdataD[0] = expData(0, 1);
    #1;
    checkOutput("prerst_m_wdata_b2", m_if.wdata, expData(0, 1));
    resetn = 1'b0;
    #1;
    checkOutput("midrst_grant", grant, 2'b00);
    checkOutput("midrst_m_wvalid", m_if.wvalid, 1'b0);
    checkOutput("midrst_m_wdata", m_if.wdata, 64'd0);
    checkOutput("midrst_m_wlast", m_if.wlast, 1'b0);
    checkOutput("midrst_wready", wreadyO, 2'b00);
    checkOutput("midrst_m_awvalid", m_if.awvalid, 1'b0);
    wvalidD[0] = 1'b0;
    mWready    = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    applyStimulus(1, 8'd3, 32'h0000_2400, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
